gateway_array: RTL and testbench



---
 rtl/plic_pkg.sv | 19 +
 rtl/gateway_array_if.sv | 31 +++
 rtl/gateway_cell.sv | 147 ++++++++++++++
 rtl/gateway_array.sv | 41 ++++
 tb/tb_gateway_array.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/plic_pkg.sv
// -----------------------------------------------------------------------------
// plic_pkg
// Shared types and helpers for the PLIC interrupt gateway bank.
//   trig_e   : per-source trigger mode encoding (matches the type_i bit)
//   cnt_max  : saturation value of a CNT_W-bit edge pending counter
// -----------------------------------------------------------------------------
package plic_pkg;

    typedef enum logic {
        TRIG_LEVEL = 1'b0,
        TRIG_EDGE  = 1'b1
    } trig_e;

    // Largest value an unsigned counter of width w can hold.
    function automatic int unsigned cnt_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/gateway_array_if.sv
// -----------------------------------------------------------------------------
// gateway_array_if
// Bundle of the per-source interrupt lines between devices/arbitration core
// (master side) and the gateway bank (slave side). One bit per source.
//   irq_i   : raw interrupt lines, active high          (master -> slave)
//   type_i  : trigger mode, 0 = level, 1 = rising edge   (master -> slave)
//   ready_i : core accepts the request of source i       (master -> slave)
//   comp_i  : completion pulse for source i              (master -> slave)
//   valid_o : request of source i to the core            (slave -> master)
//   ovf_o   : edge dropped on a saturated counter        (slave -> master)
// -----------------------------------------------------------------------------
interface gateway_array_if #(
    parameter int NSRC = 32
);
    logic [NSRC-1:0] irq_i;
    logic [NSRC-1:0] type_i;
    logic [NSRC-1:0] ready_i;
    logic [NSRC-1:0] comp_i;
    logic [NSRC-1:0] valid_o;
    logic [NSRC-1:0] ovf_o;

    modport master (
        output irq_i, type_i, ready_i, comp_i,
        input  valid_o, ovf_o
    );

    modport slave (
        input  irq_i, type_i, ready_i, comp_i,
        output valid_o, ovf_o
    );
endinterface

// File: rtl/gateway_cell.sv
// -----------------------------------------------------------------------------
// gateway_cell
// One PLIC interrupt gateway: optional input synchroniser, rising-edge detect,
// saturating edge pending counter and in-flight claim flag.
// Optional feature macro: PLIC_GATEWAY_SYNC_EN (2-flop synchroniser on irq_i).
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   irq_i          : raw interrupt line
//   type_i         : 0 = level, 1 = rising edge
//   ready_i        : core accepts this request in the current cycle
//   comp_i         : completion pulse from the target
//   valid_o        : request to the core (combinational from state)
//   ovf_o          : registered pulse, the cycle after an edge was dropped
//                    because the counter was already saturated
// -----------------------------------------------------------------------------
module gateway_cell
    import plic_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic irq_i,
    input  logic type_i,
    input  logic ready_i,
    input  logic comp_i,
    output logic valid_o,
    output logic ovf_o
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic             irq_s;
    logic             prev_r;
    logic             type_r;
    logic             inflight_r;
    logic [CNT_W-1:0] cnt_r;
    logic             ovf_r;

    logic             rise_s;
    logic             edge_mode_s;
    logic             valid_s;
    logic             hs_s;
    logic             inflight_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             ovf_nxt_s;

`ifdef PLIC_GATEWAY_SYNC_EN
    logic sync1_r;
    logic sync2_r;

    // Two-flop synchroniser for an asynchronous device line.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= irq_i;
            sync2_r <= sync1_r;
        end
    end

    assign irq_s = sync2_r;
`else
    assign irq_s = irq_i;
`endif

    assign rise_s      = irq_s & ~prev_r;
    assign edge_mode_s = (trig_e'(type_i) == TRIG_EDGE);

    // Request generation; gated by reset so a level line held high cannot
    // present a request while the bank is in reset.
    always_comb begin
        valid_s = 1'b0;
        if (!rst_n_i) begin
            valid_s = 1'b0;
        end else if (inflight_r) begin
            valid_s = 1'b0;
        end else if (edge_mode_s) begin
            valid_s = (cnt_r != CNT_ZERO);
        end else begin
            valid_s = irq_s;
        end
    end

    assign hs_s = valid_s & ready_i;

    // Next-state logic for the claim flag and the edge pending counter.
    always_comb begin
        inflight_nxt_s = inflight_r;
        cnt_nxt_s      = cnt_r;
        ovf_nxt_s      = 1'b0;

        // A handshake only happens while not in flight, so a completion that
        // coincides with it is ignored by construction.
        if (comp_i && inflight_r) begin
            inflight_nxt_s = 1'b0;
        end else if (hs_s) begin
            inflight_nxt_s = 1'b1;
        end else begin
            inflight_nxt_s = inflight_r;
        end

        if (type_i != type_r) begin
            // Mode change discards any pending edges, including one arriving now.
            cnt_nxt_s = CNT_ZERO;
        end else if (!edge_mode_s) begin
            cnt_nxt_s = CNT_ZERO;
        end else begin
            case ({rise_s, hs_s})
                2'b10: begin
                    if (cnt_r == CNT_MAX) begin
                        cnt_nxt_s = cnt_r;
                        ovf_nxt_s = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
                2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
                default: cnt_nxt_s = cnt_r; // idle, or edge and handshake cancel
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prev_r     <= 1'b0;
            type_r     <= 1'b0;
            inflight_r <= 1'b0;
            cnt_r      <= CNT_ZERO;
            ovf_r      <= 1'b0;
        end else begin
            prev_r     <= irq_s;
            type_r     <= type_i;
            inflight_r <= inflight_nxt_s;
            cnt_r      <= cnt_nxt_s;
            ovf_r      <= ovf_nxt_s;
        end
    end

    assign valid_o = valid_s;
    assign ovf_o   = ovf_r;

endmodule

// File: rtl/gateway_array.sv
// -----------------------------------------------------------------------------
// gateway_array
// Bank of NSRC independent PLIC interrupt gateways sitting between raw device
// interrupt lines and the priority/arbitration core.
// Optional feature macro: PLIC_GATEWAY_SYNC_EN (per-line 2-flop synchroniser).
// Ports:
//   clk_i   : system clock
//   rst_n_i : asynchronous active-low reset
//   bus     : gateway_array_if.slave (irq_i, type_i, ready_i, comp_i in;
//             valid_o, ovf_o out), NSRC bits each
// Parameters:
//   NSRC  : number of sources (1..1023)
//   CNT_W : width of each edge pending counter (saturates at 2^CNT_W-1)
// -----------------------------------------------------------------------------
module gateway_array
    import plic_pkg::*;
#(
    parameter int NSRC  = 32,
    parameter int CNT_W = 3
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    gateway_array_if.slave  bus
);

    for (genvar i = 0; i < NSRC; i++) begin : g_cell
        gateway_cell #(
            .CNT_W (CNT_W)
        ) u_cell (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .irq_i   (bus.irq_i[i]),
            .type_i  (bus.type_i[i]),
            .ready_i (bus.ready_i[i]),
            .comp_i  (bus.comp_i[i]),
            .valid_o (bus.valid_o[i]),
            .ovf_o   (bus.ovf_o[i])
        );
    end

endmodule

// File: tb/tb_gateway_array.sv
// -----------------------------------------------------------------------------
// tb_gateway_array
// Directed stimulus on sources 0..3 (src0 level, src1..3 edge); sources 4..31
// stay idle and are expected to stay quiet. Each step drives one cycle of
// inputs and queues the hand-derived valid_o/ovf_o for that cycle; a monitor
// on the falling edge pops and compares. ovf_o is registered, so it is
// expected one cycle after the dropped edge.
// -----------------------------------------------------------------------------
module tb_gateway_array;

    localparam int NSRC  = 32;
    localparam int CNT_W = 3;

    typedef struct {
        string       tag;
        logic [31:0] v;
        logic [31:0] o;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] typ = 4'b1110;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    gateway_array_if #(.NSRC(NSRC)) bus ();

    gateway_array #(
        .NSRC  (NSRC),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus plus the expected outputs for that cycle.
    task automatic step(input string tag, input logic rst,
                        input logic [3:0] irq, input logic [3:0] rdy,
                        input logic [3:0] cmp, input logic [3:0] ev,
                        input logic [3:0] eo);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n       = rst;
        bus.irq_i   = {28'd0, irq};
        bus.type_i  = {28'd0, typ};
        bus.ready_i = {28'd0, rdy};
        bus.comp_i  = {28'd0, cmp};
        e.tag = tag;
        e.v   = {28'd0, ev};
        e.o   = {28'd0, eo};
        sb_q.push_back(e);
    endtask

    // Monitor: compare outputs mid-cycle against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (bus.valid_o !== e.v) begin
                errors++;
                $display("FAIL %s valid_o got %h expected %h", e.tag, bus.valid_o, e.v);
            end
            checks++;
            if (bus.ovf_o !== e.o) begin
                errors++;
                $display("FAIL %s ovf_o got %h expected %h", e.tag, bus.ovf_o, e.o);
            end
        end
    end

    initial begin
        bus.irq_i   = '0;
        bus.type_i  = {28'd0, typ};
        bus.ready_i = '0;
        bus.comp_i  = '0;

        // Reset: level line high must not leak through.
        step("reset", 1'b0, 4'h1, 4'hF, 4'h0, 4'h0, 4'h0);
        step("reset", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

        // Level source 0: same-cycle request, blocked while in flight, rearm.
        step("lvl_req",      1'b1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h0);
        step("lvl_inflight", 1'b1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
        step("lvl_comp",     1'b1, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0);
        step("lvl_rearm",    1'b1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0);
        step("lvl_drop",     1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

        // Completion while idle is ignored; hs+comp together leaves it in flight.
        step("comp_idle",      1'b1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0);
        step("comp_idle_hold", 1'b1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0);
        step("hs_comp",        1'b1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0);
        step("hs_comp_infl",   1'b1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
        step("hs_comp_done",   1'b1, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0);
        step("lvl_idle",       1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

        // Edge source 1: three edges, then three handshake/complete rounds.
        step("edge_cnt",      1'b1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0);
        step("edge_cnt",      1'b1, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0);
        step("edge_cnt",      1'b1, 4'h2, 4'h0, 4'h0, 4'h2, 4'h0);
        step("edge_cnt",      1'b1, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0);
        step("edge_cnt",      1'b1, 4'h2, 4'h0, 4'h0, 4'h2, 4'h0);
        step("edge_hs",       1'b1, 4'h0, 4'h2, 4'h0, 4'h2, 4'h0);
        step("edge_inflight", 1'b1, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0);
        step("edge_comp",     1'b1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0);
        for (int r = 0; r < 2; r++) begin
            step("edge_hs",   1'b1, 4'h0, 4'h2, 4'h0, 4'h2, 4'h0);
            step("edge_comp", 1'b1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0);
        end
        step("edge_empty",    1'b1, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0);
        step("edge_idle",     1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

        // Mode change on source 1 clears the count and drops a coincident edge.
        step("mode_pre",   1'b1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0);
        step("mode_pre",   1'b1, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0);
        typ = 4'b1100;
        step("mode_lvl",   1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        typ = 4'b1110;
        step("mode_clr",   1'b1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0);
        step("mode_clr",   1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        step("mode_edge",  1'b1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0);
        step("mode_edge",  1'b1, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0);
        step("mode_hs",    1'b1, 4'h0, 4'h2, 4'h0, 4'h2, 4'h0);
        step("mode_comp",  1'b1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0);
        step("mode_idle",  1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

        // Saturation on source 2: nine edges, 8th and 9th overflow, seven served.
        for (int k = 0; k < 18; k++) begin
            step("sat_edges", 1'b1, {1'b0, (k % 2 == 0), 2'b00}, 4'h0, 4'h0,
                 {1'b0, (k >= 1), 2'b00}, {1'b0, (k == 15 || k == 17), 2'b00});
        end
        for (int r = 0; r < 7; r++) begin
            step("sat_hs",   1'b1, 4'h0, 4'h4, 4'h0, 4'h4, 4'h0);
            step("sat_comp", 1'b1, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0);
        end
        step("sat_empty", 1'b1, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0);

        // Source 3: edge and handshake in one cycle with cnt = 2 keeps cnt = 2.
        step("sim_pre",     1'b1, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0);
        step("sim_pre",     1'b1, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0);
        step("sim_pre",     1'b1, 4'h8, 4'h0, 4'h0, 4'h8, 4'h0);
        step("sim_pre",     1'b1, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0);
        step("edge_and_hs", 1'b1, 4'h8, 4'h8, 4'h0, 4'h8, 4'h0);
        step("sim_infl",    1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        step("sim_comp",    1'b1, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0);
        step("cnt_kept",    1'b1, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0);
        for (int r = 0; r < 2; r++) begin
            step("sim_hs",   1'b1, 4'h0, 4'h8, 4'h0, 4'h8, 4'h0);
            step("sim_comp", 1'b1, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0);
        end
        step("cnt_two",     1'b1, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0);

        // Reset mid-operation: source 2 at cnt = 5 and in flight.
        for (int k = 0; k < 12; k++) begin
            step("rst_pre", 1'b1, {1'b0, (k % 2 == 0), 2'b00}, 4'h0, 4'h0,
                 {1'b0, (k >= 1), 2'b00}, 4'h0);
        end
        step("rst_pre_hs",   1'b1, 4'h0, 4'h4, 4'h0, 4'h4, 4'h0);
        step("rst_pre_infl", 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        step("rst_async",    1'b0, 4'h1, 4'hF, 4'h0, 4'h0, 4'h0);
        step("rst_async",    1'b0, 4'h1, 4'hF, 4'h0, 4'h0, 4'h0);
        for (int k = 0; k < 3; k++) begin
            step("rst_release", 1'b1, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
        end
        step("rst_new_lvl",  1'b1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0);
        step("rst_new_edge", 1'b1, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0);
        step("rst_new_edge", 1'b1, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0);

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
